// File: rtl/hazard_fifo_pkg.sv
// Shared helpers for the hazard tag FIFO: pointer/count widths, the
// "no register" tag value and the offset of a lookup port's packed tag slice.
package hazard_fifo_pkg;

    // Tag value that names no register and therefore never hits.
    localparam int TAG_ZERO = 0;

    // Pointer width for a power-of-two depth; pointers wrap by overflow.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Count width: one extra bit so that "completely full" is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // LSB of lookup port k inside a packed tag vector.
    function automatic int lk_lsb(input int k, input int tag_w);
        return k * tag_w;
    endfunction

endpackage

// File: rtl/hazard_tag_match.sv
// One hazard lookup port: compares a source tag against every valid entry.
module hazard_tag_match
    import hazard_fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int TAG_WIDTH = 5
) (
    input  logic [DEPTH*TAG_WIDTH-1:0] entry_tags,
    input  logic [DEPTH-1:0]           entry_valid,
    input  logic                       lk_en,
    input  logic [TAG_WIDTH-1:0]       lk_tag,
    output logic                       hit
);

    logic any_match;

    // OR of per-entry matches; a zero tag or a disabled port never hits.
    always_comb begin
        any_match = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (entry_valid[e] && (entry_tags[e*TAG_WIDTH +: TAG_WIDTH] == lk_tag))
                any_match = 1'b1;
        end
        hit = lk_en && (lk_tag != TAG_WIDTH'(TAG_ZERO)) && any_match;
    end

endmodule

// File: rtl/hazard_tag_fifo.sv
// Write-back scoreboard FIFO with per-entry valid bits, N hazard lookup
// ports, flush, almost-full/empty thresholds and sticky error flags.
//
// Request/accept semantics: i_wr_en and i_rd_en are requests, not
// handshakes with backpressure. A read is accepted whenever the FIFO is not
// empty; a write is accepted when not full, or when full and a read is
// accepted in the same cycle. A request that is not accepted is dropped and
// raises the matching sticky error flag (unless i_flush is high, which
// overrides every request for that cycle).
module hazard_tag_fifo
    import hazard_fifo_pkg::*;
#(
    parameter int DATA_DEPTH    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int TAG_WIDTH     = 5,
    parameter int NUM_LOOKUP    = 2,
    parameter int AFULL_THRESH  = DATA_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_flush,
    input  logic                            i_wr_en,
    input  logic [TAG_WIDTH-1:0]            i_wr_tag,
    input  logic [DATA_WIDTH-1:0]           i_wr_data,
    input  logic                            i_rd_en,
    output logic [DATA_WIDTH-1:0]           o_rd_data,
    output logic [TAG_WIDTH-1:0]            o_rd_tag,
    output logic                            o_full,
    output logic                            o_empty,
    output logic                            o_afull,
    output logic                            o_aempty,
    output logic [$clog2(DATA_DEPTH):0]     o_count,
    input  logic [NUM_LOOKUP-1:0]           i_lk_en,
    input  logic [NUM_LOOKUP*TAG_WIDTH-1:0] i_lk_tag,
    output logic [NUM_LOOKUP-1:0]           o_lk_hit,
    output logic                            o_hit_any,
    input  logic                            i_err_clr,
    output logic                            o_ovf,
    output logic                            o_udf
);

    localparam int PTR_W = ptr_width(DATA_DEPTH);
    localparam int CNT_W = cnt_width(DATA_DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DATA_DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0]           mem_data [DATA_DEPTH];
    logic [TAG_WIDTH-1:0]            mem_tag  [DATA_DEPTH];
    logic [DATA_DEPTH*TAG_WIDTH-1:0] tags_flat;
    logic [DATA_DEPTH-1:0]           valid_q;
    logic [PTR_W-1:0]                wr_ptr;
    logic [PTR_W-1:0]                rd_ptr;
    logic [CNT_W-1:0]                count;
    logic                            rd_acc, wr_acc, do_rd, do_wr;
    logic                            ovf_set, udf_set;

    // Status is purely a decode of the registered count.
    assign o_count  = count;
    assign o_empty  = (count == '0);
    assign o_full   = (count == DEPTH_C);
    assign o_afull  = (count >= AFULL_C);
    assign o_aempty = (count <= AEMPTY_C);

    // Accept logic; a full FIFO still takes a write when a pop frees a slot.
    assign rd_acc  = i_rd_en & ~o_empty;
    assign wr_acc  = i_wr_en & (~o_full | rd_acc);
    assign do_rd   = rd_acc & ~i_flush;
    assign do_wr   = wr_acc & ~i_flush;
    assign ovf_set = i_wr_en & ~wr_acc & ~i_flush;
    assign udf_set = i_rd_en & o_empty & ~i_flush;

    // Show-ahead head entry, forced to zero while empty.
    assign o_rd_data = o_empty ? '0 : mem_data[rd_ptr];
    assign o_rd_tag  = o_empty ? '0 : mem_tag[rd_ptr];

    // Flatten stored tags so every lookup port sees the whole array.
    always_comb begin
        tags_flat = '0;
        for (int e = 0; e < DATA_DEPTH; e++)
            tags_flat[e*TAG_WIDTH +: TAG_WIDTH] = mem_tag[e];
    end

    // Payload/tag storage; not reset, the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_data[wr_ptr] <= i_wr_data;
            mem_tag[wr_ptr]  <= i_wr_tag;
        end
    end

    // Pointers, occupancy and valid bits; flush beats any read/write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else if (i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (do_rd) begin
                rd_ptr          <= rd_ptr + PTR_W'(1);
                valid_q[rd_ptr] <= 1'b0;
            end
            // Placed after the clear so a full read+write to the same slot
            // leaves the new entry valid.
            if (do_wr) begin
                wr_ptr          <= wr_ptr + PTR_W'(1);
                valid_q[wr_ptr] <= 1'b1;
            end
            count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ovf <= 1'b0;
            o_udf <= 1'b0;
        end else begin
            o_ovf <= ovf_set | (o_ovf & ~i_err_clr);
            o_udf <= udf_set | (o_udf & ~i_err_clr);
        end
    end

    // One matcher per lookup port.
    for (genvar k = 0; k < NUM_LOOKUP; k++) begin : g_lookup
        hazard_tag_match #(
            .DEPTH     (DATA_DEPTH),
            .TAG_WIDTH (TAG_WIDTH)
        ) u_match (
            .entry_tags  (tags_flat),
            .entry_valid (valid_q),
            .lk_en       (i_lk_en[k]),
            .lk_tag      (i_lk_tag[lk_lsb(k, TAG_WIDTH) +: TAG_WIDTH]),
            .hit         (o_lk_hit[k])
        );
    end

    assign o_hit_any = |o_lk_hit;

endmodule

// File: tb/tb_hazard_tag_fifo.sv
// Directed and random stimulus for hazard_tag_fifo against a queue model.
module tb_hazard_tag_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int TW    = 5;
  localparam int NL    = 2;
  localparam int AFULL = DEPTH - 2;
  localparam int AEMPT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              flush, wr_en, rd_en, err_clr;
  logic [TW-1:0]     wr_tag;
  logic [DW-1:0]     wr_data;
  logic [NL-1:0]     lk_en;
  logic [NL*TW-1:0]  lk_tag;
  logic [DW-1:0]     rd_data;
  logic [TW-1:0]     rd_tag;
  logic              full, empty, afull, aempty, hit_any, ovf, udf;
  logic [3:0]        count;
  logic [NL-1:0]     lk_hit;

  hazard_tag_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (flush),
    .i_wr_en   (wr_en),
    .i_wr_tag  (wr_tag),
    .i_wr_data (wr_data),
    .i_rd_en   (rd_en),
    .o_rd_data (rd_data),
    .o_rd_tag  (rd_tag),
    .o_full    (full),
    .o_empty   (empty),
    .o_afull   (afull),
    .o_aempty  (aempty),
    .o_count   (count),
    .i_lk_en   (lk_en),
    .i_lk_tag  (lk_tag),
    .o_lk_hit  (lk_hit),
    .o_hit_any (hit_any),
    .i_err_clr (err_clr),
    .o_ovf     (ovf),
    .o_udf     (udf)
  );

  // ---------------- reference model ----------------
  logic [TW+DW-1:0] exp_q[$];   // {tag, data}, head at index 0
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Compare every output against the model's current contents and inputs.
  task automatic check_outputs(input string tag);
    int n;
    logic [NL-1:0] e_hit;
    logic [TW-1:0] t;
    n = exp_q.size();
    chk({tag, ".count"},  64'(count),  64'(n));
    chk({tag, ".empty"},  64'(empty),  64'(n == 0));
    chk({tag, ".full"},   64'(full),   64'(n == DEPTH));
    chk({tag, ".afull"},  64'(afull),  64'(n >= AFULL));
    chk({tag, ".aempty"}, 64'(aempty), 64'(n <= AEMPT));
    chk({tag, ".rd_data"}, 64'(rd_data), (n > 0) ? 64'(exp_q[0][DW-1:0]) : 64'd0);
    chk({tag, ".rd_tag"},  64'(rd_tag),  (n > 0) ? 64'(exp_q[0][TW+DW-1:DW]) : 64'd0);
    e_hit = '0;
    for (int k = 0; k < NL; k++) begin
      t = lk_tag[k*TW +: TW];
      if (lk_en[k] && t != 0)
        foreach (exp_q[i]) if (exp_q[i][TW+DW-1:DW] == t) e_hit[k] = 1'b1;
    end
    chk({tag, ".lk_hit"},  64'(lk_hit),  64'(e_hit));
    chk({tag, ".hit_any"}, 64'(hit_any), 64'(|e_hit));
    chk({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
    chk({tag, ".udf"}, 64'(udf), 64'(m_udf));
  endtask

  // Apply the FIFO rules to the model for one rising edge.
  task automatic model_edge();
    int n;
    bit ra, wa, os, us;
    n = exp_q.size();
    os = 0; us = 0;
    if (flush) begin
      exp_q.delete();
    end else begin
      ra = rd_en && n > 0;
      wa = wr_en && (n < DEPTH || ra);
      os = wr_en && !wa;
      us = rd_en && n == 0;
      if (ra) void'(exp_q.pop_front());
      if (wa) exp_q.push_back({wr_tag, wr_data});
    end
    m_ovf = os ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
    m_udf = us ? 1'b1 : (err_clr ? 1'b0 : m_udf);
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: drive, check, clock, update model.
  task automatic step(input string tag, input logic f, input logic w, input logic [TW-1:0] wt,
                      input logic [DW-1:0] wd, input logic r, input logic [NL-1:0] le,
                      input logic [NL*TW-1:0] lt, input logic ec);
    flush = f; wr_en = w; wr_tag = wt; wr_data = wd; rd_en = r;
    lk_en = le; lk_tag = lt; err_clr = ec;
    #1 check_outputs(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [TW-1:0] t, input logic [DW-1:0] d);
    step(tag, 0, 1, t, d, 0, '0, '0, 0);
  endtask

  task automatic pop(input string tag);
    step(tag, 0, 0, '0, '0, 1, '0, '0, 0);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, '0, '0, 0, '0, '0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    flush = 0; wr_en = 0; wr_tag = '0; wr_data = '0; rd_en = 0;
    lk_en = '0; lk_tag = '0; err_clr = 0;
    repeat (3) @(negedge clk);
    #1 check_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fill with tags 1..8, drain in order.
    for (int i = 1; i <= 8; i++) push("fill", TW'(i), DW'(32'hA0 + i));
    idle("full");
    for (int i = 0; i < 8; i++) pop("drain");
    idle("drained");

    // Full with simultaneous read+write: both accepted.
    for (int i = 1; i <= 8; i++) push("fill2", TW'(i), DW'(32'hB0 + i));
    step("full_rw", 0, 1, 5'd9, 32'hB9, 1, '0, '0, 0);
    for (int i = 0; i < 8; i++) pop("drain2");
    idle("drained2");

    // Lookup visibility: port0 tag 5, port1 tag 0.
    step("lk_wr", 0, 1, 5'd5, 32'h55, 0, 2'b11, {5'd0, 5'd5}, 0);
    step("lk_vis", 0, 0, '0, '0, 0, 2'b11, {5'd0, 5'd5}, 0);
    step("lk_pop", 0, 0, '0, '0, 1, 2'b11, {5'd0, 5'd5}, 0);
    step("lk_gone", 0, 0, '0, '0, 0, 2'b11, {5'd5, 5'd5}, 0);

    // Flush with a write in the same cycle.
    for (int i = 1; i <= 3; i++) push("pre_flush", TW'(i + 10), DW'(i));
    step("flush", 1, 1, 5'd20, 32'h20, 0, 2'b11, {5'd12, 5'd11}, 0);
    step("post_flush", 0, 0, '0, '0, 0, 2'b11, {5'd12, 5'd11}, 0);

    // Sticky errors and clear.
    pop("udf_set");
    idle("udf_hold");
    for (int i = 1; i <= 8; i++) push("fill3", TW'(i), DW'(32'hC0 + i));
    push("ovf_set", 5'd30, 32'hDEAD);
    idle("ovf_hold");
    step("err_clr", 0, 0, '0, '0, 0, '0, '0, 1);
    idle("err_cleared");

    // Asynchronous reset in the middle of a burst at count 4.
    for (int i = 0; i < 8; i++) pop("drain3");
    for (int i = 1; i <= 4; i++) push("burst", TW'(i), DW'(32'hE0 + i));
    wr_en = 1; wr_tag = 5'd7; wr_data = 32'hE7; lk_en = 2'b11; lk_tag = {5'd2, 5'd1};
    #2 rst_n = 1'b0;
    exp_q.delete(); m_ovf = 0; m_udf = 0;
    #1 check_outputs("async_rst");
    wr_en = 0; lk_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random interleaved traffic including wrap-around.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 99) < 55,
           TW'($urandom_range(0, 9)),
           DW'($urandom),
           $urandom_range(0, 99) < 45,
           NL'($urandom_range(0, 3)),
           {TW'($urandom_range(0, 9)), TW'($urandom_range(0, 9))},
           $urandom_range(0, 29) == 0);
    end
    idle("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_tag_fifo.md
Name: hazard_tag_fifo

Overview:
Parametrised successor to the team's scoreboard FIFO for the RISC-V pipeline. It buffers in-flight write-back entries (data plus destination-register tag) and compares a configurable number of source-register lookups against every valid entry, to flag RAW hazards. Over the previous generation it adds:
- N lookup ports
- correct simultaneous read/write when full
- explicit per-entry valid bits
- flush
- almost-full/almost-empty thresholds
- sticky overflow/underflow flags

Parameters:
DATA_DEPTH, 8, entry count; power of two, >= 2
DATA_WIDTH, 32, payload width
TAG_WIDTH, 5, register-tag width; tag value 0 never hits
NUM_LOOKUP, 2, number of independent hazard lookup ports
AFULL_THRESH, DATA_DEPTH-2, o_afull asserted when count >= this
AEMPTY_THRESH, 2, o_aempty asserted when count <= this

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; one clock; asynchronous, active-low
i_flush  in  1  discard all entries
i_wr_en  in  1  write request
i_wr_tag  in  TAG_WIDTH  destination tag of write
i_wr_data  in  DATA_WIDTH  payload of write
i_rd_en  in  1  read (pop) request
o_rd_data  out  DATA_WIDTH  head payload, 0 when empty
o_rd_tag  out  TAG_WIDTH  head tag, 0 when empty
o_full  out  1  count == DATA_DEPTH
o_empty  out  1  count == 0
o_afull  out  1  count >= AFULL_THRESH
o_aempty  out  1  count <= AEMPTY_THRESH
o_count  out  $clog2(DATA_DEPTH)+1  occupancy
i_lk_en  in  NUM_LOOKUP  per-port lookup enable
i_lk_tag  in  NUM_LOOKUP*TAG_WIDTH  packed lookup tags; port k at [k*TAG_WIDTH +: TAG_WIDTH]
o_lk_hit  out  NUM_LOOKUP  per-port hit
o_hit_any  out  1  OR of o_lk_hit
i_err_clr  in  1  clear sticky error flags
o_ovf  out  1  sticky overflow
o_udf  out  1  sticky underflow

Behaviour:
- Reset (rst_n low, async): wr_ptr, rd_ptr, count, all valid bits and o_ovf/o_udf = 0.
  - Hence o_empty=1, o_full=0, o_aempty=1, o_afull=0 (for AFULL_THRESH>0), o_lk_hit=0, o_rd_data/o_rd_tag=0.
  - Data/tag storage is not reset.
- rd_acc = i_rd_en & !o_empty.
- wr_acc = i_wr_en & (!o_full | rd_acc). Full plus simultaneous read accepts both.
- On rd_acc: valid[rd_ptr] cleared, rd_ptr+1.
- On wr_acc: data/tag written at wr_ptr, valid[wr_ptr] set, wr_ptr+1.
- Pointers wrap modulo DATA_DEPTH (natural overflow of log2 width).
- count_next = count + wr_acc - rd_acc. Empty with read+write: only the write is accepted, count +1.
- Read is show-ahead: o_rd_data/o_rd_tag are combinational from rd_ptr, valid same cycle as !o_empty. Write-to-read latency is 1 cycle.
- Status outputs are combinational from registered count.
- Lookup (combinational, zero latency): o_lk_hit[k] = i_lk_en[k] & (tag_k != 0) & OR over entries e of (valid[e] & tag[e]==tag_k).
  - An entry written this cycle is visible from the next cycle.
  - An entry popped this cycle is still visible this cycle.
- Flush: i_flush has priority over rd/wr. Next cycle: pointers, count and valid bits = 0. Lookups during the flush cycle still see old contents.
  - i_flush, rd_acc and wr_acc are suppressed for that cycle; error flags are not set by requests in the flush cycle.
- Errors:
  - o_ovf set when i_wr_en & !wr_acc & !i_flush.
  - o_udf set when i_rd_en & o_empty & !i_flush.
  - Both hold until i_err_clr (set has priority over clear in the same cycle) or reset.
- Reset mid-operation: all state returns to reset values immediately. No partial entry survives.

Decomposition:
- Package hazard_fifo_pkg: ptr/count width functions, TAG_ZERO constant, packed lookup-slice helper.
- Sub-module hazard_tag_match: one lookup port vs all entries (tags, valid vector, lookup tag, enable -> hit). Instantiated NUM_LOOKUP times via generate.
- Storage, pointers, counter and flags stay in the top module.

Test Plan:
- Reset, then write tags 1..8 (data 0xA0+i) -> o_full=1, o_count=8, o_afull=1; reads return 0xA1..0xA8 in order, then o_empty=1, o_rd_data=0.
- Full, i_rd_en=i_wr_en=1 with tag 9 -> count stays 8, o_ovf=0; after 8 more pops the last entry read is tag 9.
- Write tag 5; port0 looks up 5, port1 looks up 0 (both enabled) -> cycle of write: hits 00; next cycle: o_lk_hit=01. Pop it -> hit drops the cycle after pop.
- 3 entries, assert i_flush together with i_wr_en -> next cycle o_count=0, o_empty=1, no hits, o_ovf=0.
- Empty, i_rd_en=1 -> o_udf=1 and sticky. Full, i_wr_en only -> o_ovf=1. i_err_clr -> both 0 next cycle.
- Drop rst_n asynchronously mid-burst (count=4) -> outputs reach reset values before the next clk edge. Wrap-around test: 20 pushes/pops interleaved, data order preserved.
